// File: rtl/bit_scan_pkg.sv
// bit_scan_pkg: shared types and helpers for the bit_scan_encoder slice.
//   scan_state_t : scanner FSM state encoding
//   SCAN_MAX_W   : widest mask the onehot_le1 helper can inspect
//   onehot_le1() : 1 when at most one bit of the (zero-extended) mask is set
package bit_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Callers size-cast their mask up to this width; WIDTH must not exceed it.
  localparam int SCAN_MAX_W = 1024;

  // Clearing the lowest set bit leaves zero iff at most one bit was set.
  function automatic bit onehot_le1(input logic [SCAN_MAX_W-1:0] mask);
    return (mask & (mask - SCAN_MAX_W'(1))) == '0;
  endfunction

endpackage

// File: rtl/lead_one_encoder.sv
// lead_one_encoder: combinational leading-one finder.
//   WIDTH   : mask width (power of two, >= 2)
//   mask    : bits to inspect
//   idx     : MSB-relative position of the highest set bit (0 when mask is 0)
//   is_zero : mask has no bits set
module lead_one_encoder #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             is_zero
);

  // Walk LSB to MSB so the highest set bit is the last one written.
  always_comb begin
    idx     = '0;
    is_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i]) begin
        idx     = IDX_W'(WIDTH - 1 - i);
        is_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bit_scan_encoder.sv
// bit_scan_encoder: accepts a WIDTH-bit mask over valid/ready and emits the
// MSB-relative index of every set bit, highest first, one per cycle.
//
// Build option: define BIT_SCAN_SKIP_ZERO_EN to drop all-zero masks silently
// (no beat, out_zero tied 0). Undefined, a zero mask yields one beat with
// out_idx 0, out_last 1, out_zero 1.
//
// Ports:
//   clk       : clock, all state on rising edge
//   reset     : synchronous active-high reset
//   in_valid  : in_mask valid
//   in_ready  : mask accepted this cycle (combinational from out_ready)
//   in_mask   : bitmask to scan
//   out_valid : beat valid
//   out_ready : consumer takes current beat
//   out_idx   : MSB-relative index of highest remaining set bit
//   out_last  : final beat of this mask
//   out_zero  : beat stands for an all-zero mask
//
// state | meaning
// IDLE  | no residual held, ready for a mask
// SCAN  | residual held, presenting one beat per cycle
module bit_scan_encoder
  import bit_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero
);

  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

  scan_state_t      state_q, state_d;
  logic [WIDTH-1:0] residual_q, residual_d;
`ifndef BIT_SCAN_SKIP_ZERO_EN
  logic             zero_q, zero_d;
`endif

  logic [IDX_W-1:0]      lead_idx;
  logic                  res_zero;
  logic [SCAN_MAX_W-1:0] res_ext;
  logic                  accept;
  logic                  beat_done;

  lead_one_encoder #(.WIDTH(WIDTH)) u_lead (
    .mask    (residual_q),
    .idx     (lead_idx),
    .is_zero (res_zero)
  );

  assign res_ext   = SCAN_MAX_W'(residual_q);
  assign accept    = in_valid && in_ready;
  assign beat_done = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      residual_q <= '0;
`ifndef BIT_SCAN_SKIP_ZERO_EN
      zero_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
`ifndef BIT_SCAN_SKIP_ZERO_EN
      zero_q     <= zero_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
`ifndef BIT_SCAN_SKIP_ZERO_EN
    zero_d     = zero_q;
`endif
    if (state_q == SCAN && beat_done) begin
      // A zero-mask beat has no bit to clear.
      if (!res_zero) residual_d = residual_q & ~(MSB_ONE >> lead_idx);
      if (out_last)  state_d    = IDLE;
    end
    // Accept only happens from IDLE or on the last-beat handshake, so it
    // always overrides the residual update above.
    if (accept) begin
`ifdef BIT_SCAN_SKIP_ZERO_EN
      if (in_mask == '0) begin
        state_d    = IDLE;
        residual_d = '0;
      end else begin
        state_d    = SCAN;
        residual_d = in_mask;
      end
`else
      state_d    = SCAN;
      residual_d = in_mask;
      zero_d     = (in_mask == '0);
`endif
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    if (state_q == SCAN) begin
      out_valid = 1'b1;
      out_idx   = lead_idx;
      out_last  = onehot_le1(res_ext);
`ifndef BIT_SCAN_SKIP_ZERO_EN
      out_zero  = zero_q;
`endif
    end
    in_ready = !reset && (state_q == IDLE || (out_valid && out_last && out_ready));
  end

endmodule
